// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   wb_state_e   - writeback control FSM states (RUN, FLUSH)
//   ECODE_W      - exception code width
//   ESUBCODE_W   - exception sub-code width
//   EXC_CODE_W   - packed per-source code {esubcode, ecode}
//   CSR_NUM_W    - CSR address width
//   RF_ADDR_W    - register file address width
package wb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_e;

    localparam int ECODE_W    = 6;
    localparam int ESUBCODE_W = 9;
    localparam int EXC_CODE_W = ECODE_W + ESUBCODE_W;
    localparam int CSR_NUM_W  = 14;
    localparam int RF_ADDR_W  = 5;

endpackage

// File: rtl/wb_exc_prio.sv
// wb_exc_prio: fixed-priority exception code selector.
// Picks the {esubcode, ecode} of the lowest-index raised source; index 0 has
// the highest priority. Outputs are zero when no source is raised.
// Ports:
//   exc_vec   in  NUM_EXC             raised exception sources
//   exc_code  in  EXC_CODE_W*NUM_EXC  per-source {esubcode[8:0], ecode[5:0]}
//   ecode     out ECODE_W             selected exception code
//   esubcode  out ESUBCODE_W          selected exception sub-code
module wb_exc_prio
    import wb_pkg::*;
#(
    parameter int NUM_EXC = 4
) (
    input  logic [NUM_EXC-1:0]            exc_vec,
    input  logic [EXC_CODE_W*NUM_EXC-1:0] exc_code,
    output logic [ECODE_W-1:0]            ecode,
    output logic [ESUBCODE_W-1:0]         esubcode
);

    // seen[gi] is set when any source below index gi is raised; a source only
    // wins if nothing of higher priority (lower index) is raised.
    logic [NUM_EXC:0]          seen;
    logic [EXC_CODE_W-1:0]     masked [NUM_EXC];
    logic [EXC_CODE_W-1:0]     sel_code;

    assign seen[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EXC; gi++) begin : g_prio
            assign seen[gi+1]  = seen[gi] | exc_vec[gi];
            assign masked[gi]  = (exc_vec[gi] && !seen[gi])
                               ? exc_code[gi*EXC_CODE_W +: EXC_CODE_W]
                               : '0;
        end
    endgenerate

    // At most one masked entry is non-zero, so an OR merge is a clean mux.
    always_comb begin
        sel_code = '0;
        for (int i = 0; i < NUM_EXC; i++) begin
            sel_code = sel_code | masked[i];
        end
    end

    assign ecode    = sel_code[ECODE_W-1:0];
    assign esubcode = sel_code[EXC_CODE_W-1:ECODE_W];

endmodule

// File: rtl/wb_stage_param.sv
// wb_stage_param: pipeline writeback stage.
// Latches one instruction from the previous stage, performs register file and
// CSR writeback, stalls until the CSR file acknowledges a CSR write, and turns
// an exception or ertn into a one-cycle flush of the upstream pipeline.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   to_wb_valid           upstream instruction valid
//   wb_allow_in           stage can accept an instruction this cycle
//   wb_valid              stage holds an instruction
//   in_*                  instruction payload (pc, rf write, csr write, ertn,
//                         exception vector and per-source codes)
//   csr_wack              CSR file acknowledges the current CSR write
//   wb_pc, wb_rf_*        held pc and gated register writeback
//   wb_csr_*              gated CSR write
//   wb_ex, wb_ecode,
//   wb_esubcode, wb_ertn  exception / return-from-exception report
//   wb_flush              squash upstream (high for the single FLUSH cycle)
// Optional feature (macro WB_TRACE_EN): debug_wb_pc, debug_wb_rf_we,
// debug_wb_rf_wnum, debug_wb_rf_wdata mirror the writeback on retire, and
// retire_cnt counts retired non-exception instructions (64-bit, wrapping).
module wb_stage_param
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int WE_W    = 4,
    parameter int NUM_EXC = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          to_wb_valid,
    output logic                          wb_allow_in,
    output logic                          wb_valid,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [WE_W-1:0]               in_rf_we,
    input  logic [RF_ADDR_W-1:0]          in_rf_waddr,
    input  logic [XLEN-1:0]               in_rf_wdata,
    input  logic                          in_csr_we,
    input  logic [CSR_NUM_W-1:0]          in_csr_num,
    input  logic [XLEN-1:0]               in_csr_wdata,
    input  logic [XLEN-1:0]               in_csr_wmask,
    input  logic                          in_ertn,
    input  logic [NUM_EXC-1:0]            in_exc_vec,
    input  logic [EXC_CODE_W*NUM_EXC-1:0] in_exc_code,
    input  logic                          csr_wack,
    output logic [XLEN-1:0]               wb_pc,
    output logic [WE_W-1:0]               wb_rf_we,
    output logic [RF_ADDR_W-1:0]          wb_rf_waddr,
    output logic [XLEN-1:0]               wb_rf_wdata,
    output logic                          wb_csr_we,
    output logic [CSR_NUM_W-1:0]          wb_csr_num,
    output logic [XLEN-1:0]               wb_csr_wdata,
    output logic [XLEN-1:0]               wb_csr_wmask,
    output logic                          wb_ex,
    output logic [ECODE_W-1:0]            wb_ecode,
    output logic [ESUBCODE_W-1:0]         wb_esubcode,
    output logic                          wb_ertn,
`ifdef WB_TRACE_EN
    output logic [XLEN-1:0]               debug_wb_pc,
    output logic [WE_W-1:0]               debug_wb_rf_we,
    output logic [RF_ADDR_W-1:0]          debug_wb_rf_wnum,
    output logic [XLEN-1:0]               debug_wb_rf_wdata,
    output logic [63:0]                   retire_cnt,
`endif
    output logic                          wb_flush
);

    wb_state_e                   state_reg;
    logic                        valid_reg;
    logic [XLEN-1:0]             pc_reg;
    logic [WE_W-1:0]             rf_we_reg;
    logic [RF_ADDR_W-1:0]        rf_waddr_reg;
    logic [XLEN-1:0]             rf_wdata_reg;
    logic                        csr_we_reg;
    logic [CSR_NUM_W-1:0]        csr_num_reg;
    logic [XLEN-1:0]             csr_wdata_reg;
    logic [XLEN-1:0]             csr_wmask_reg;
    logic                        ertn_reg;
    logic [NUM_EXC-1:0]          exc_vec_reg;
    logic [EXC_CODE_W*NUM_EXC-1:0] exc_code_reg;

    logic wb_ready_go;
    logic in_run;
    logic go_flush;
    logic accept;

    wb_exc_prio #(
        .NUM_EXC (NUM_EXC)
    ) u_exc_prio (
        .exc_vec  (exc_vec_reg),
        .exc_code (exc_code_reg),
        .ecode    (wb_ecode),
        .esubcode (wb_esubcode)
    );

    assign in_run      = (state_reg == RUN);
    assign wb_valid    = valid_reg;
    assign wb_flush    = (state_reg == FLUSH);
    assign wb_ex       = valid_reg && (|exc_vec_reg);
    // Exception wins over ertn when both are present.
    assign wb_ertn     = valid_reg && ertn_reg && !wb_ex;
    assign wb_rf_we    = (valid_reg && !wb_ex) ? rf_we_reg : '0;
    assign wb_csr_we   = valid_reg && !wb_ex && csr_we_reg;
    // An ack without a pending (gated) CSR write has no effect.
    assign wb_ready_go = !wb_csr_we || csr_wack;
    assign wb_allow_in = !valid_reg || (wb_ready_go && in_run);
    assign go_flush    = valid_reg && wb_ready_go && (wb_ex || wb_ertn);
    // The instruction arriving alongside a flush-causing retire, or during
    // FLUSH itself, is squashed and never enters the stage.
    assign accept      = to_wb_valid && wb_allow_in && in_run && !go_flush;

    assign wb_pc        = pc_reg;
    assign wb_rf_waddr  = rf_waddr_reg;
    assign wb_rf_wdata  = rf_wdata_reg;
    assign wb_csr_num   = csr_num_reg;
    assign wb_csr_wdata = csr_wdata_reg;
    assign wb_csr_wmask = csr_wmask_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            valid_reg     <= 1'b0;
            pc_reg        <= '0;
            rf_we_reg     <= '0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            csr_we_reg    <= 1'b0;
            csr_num_reg   <= '0;
            csr_wdata_reg <= '0;
            csr_wmask_reg <= '0;
            ertn_reg      <= 1'b0;
            exc_vec_reg   <= '0;
            exc_code_reg  <= '0;
        end else begin
            case (state_reg)
                RUN:     if (go_flush) state_reg <= FLUSH;
                FLUSH:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase

            // go_flush implies wb_ready_go, so a flushing instruction retires
            // through the second branch.
            if (accept) begin
                valid_reg <= 1'b1;
            end else if (wb_ready_go) begin
                valid_reg <= 1'b0;
            end

            if (accept) begin
                pc_reg        <= in_pc;
                rf_we_reg     <= in_rf_we;
                rf_waddr_reg  <= in_rf_waddr;
                rf_wdata_reg  <= in_rf_wdata;
                csr_we_reg    <= in_csr_we;
                csr_num_reg   <= in_csr_num;
                csr_wdata_reg <= in_csr_wdata;
                csr_wmask_reg <= in_csr_wmask;
                ertn_reg      <= in_ertn;
                exc_vec_reg   <= in_exc_vec;
                exc_code_reg  <= in_exc_code;
            end
        end
    end

`ifdef WB_TRACE_EN
    logic        retire;
    logic [63:0] retire_cnt_reg;

    assign retire            = valid_reg && wb_ready_go;
    assign debug_wb_pc       = pc_reg;
    assign debug_wb_rf_we    = retire ? wb_rf_we : '0;
    assign debug_wb_rf_wnum  = rf_waddr_reg;
    assign debug_wb_rf_wdata = rf_wdata_reg;
    assign retire_cnt        = retire_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_reg <= '0;
        end else if (retire && !wb_ex) begin
            retire_cnt_reg <= retire_cnt_reg + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// tb_wb_stage_param: self-checking bench for wb_stage_param.
// A transaction-level model tracks what the stage holds and whether a flush
// cycle is due; outputs are compared against it every cycle at the falling
// edge, plus hand-computed expectations at key points.
module tb_wb_stage_param;

    localparam int XLEN    = 32;
    localparam int WE_W    = 4;
    localparam int NUM_EXC = 4;
    localparam int CW      = 15;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    to_wb_valid;
    logic                    wb_allow_in;
    logic                    wb_valid;
    logic [XLEN-1:0]         in_pc;
    logic [WE_W-1:0]         in_rf_we;
    logic [4:0]              in_rf_waddr;
    logic [XLEN-1:0]         in_rf_wdata;
    logic                    in_csr_we;
    logic [13:0]             in_csr_num;
    logic [XLEN-1:0]         in_csr_wdata;
    logic [XLEN-1:0]         in_csr_wmask;
    logic                    in_ertn;
    logic [NUM_EXC-1:0]      in_exc_vec;
    logic [CW*NUM_EXC-1:0]   in_exc_code;
    logic                    csr_wack;
    logic [XLEN-1:0]         wb_pc;
    logic [WE_W-1:0]         wb_rf_we;
    logic [4:0]              wb_rf_waddr;
    logic [XLEN-1:0]         wb_rf_wdata;
    logic                    wb_csr_we;
    logic [13:0]             wb_csr_num;
    logic [XLEN-1:0]         wb_csr_wdata;
    logic [XLEN-1:0]         wb_csr_wmask;
    logic                    wb_ex;
    logic [5:0]              wb_ecode;
    logic [8:0]              wb_esubcode;
    logic                    wb_ertn;
    logic                    wb_flush;
`ifdef WB_TRACE_EN
    logic [XLEN-1:0]         debug_wb_pc;
    logic [WE_W-1:0]         debug_wb_rf_we;
    logic [4:0]              debug_wb_rf_wnum;
    logic [XLEN-1:0]         debug_wb_rf_wdata;
    logic [63:0]             retire_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage_param #(.XLEN(XLEN), .WE_W(WE_W), .NUM_EXC(NUM_EXC)) dut (
        .clk          (clk),
        .reset        (reset),
        .to_wb_valid  (to_wb_valid),
        .wb_allow_in  (wb_allow_in),
        .wb_valid     (wb_valid),
        .in_pc        (in_pc),
        .in_rf_we     (in_rf_we),
        .in_rf_waddr  (in_rf_waddr),
        .in_rf_wdata  (in_rf_wdata),
        .in_csr_we    (in_csr_we),
        .in_csr_num   (in_csr_num),
        .in_csr_wdata (in_csr_wdata),
        .in_csr_wmask (in_csr_wmask),
        .in_ertn      (in_ertn),
        .in_exc_vec   (in_exc_vec),
        .in_exc_code  (in_exc_code),
        .csr_wack     (csr_wack),
        .wb_pc        (wb_pc),
        .wb_rf_we     (wb_rf_we),
        .wb_rf_waddr  (wb_rf_waddr),
        .wb_rf_wdata  (wb_rf_wdata),
        .wb_csr_we    (wb_csr_we),
        .wb_csr_num   (wb_csr_num),
        .wb_csr_wdata (wb_csr_wdata),
        .wb_csr_wmask (wb_csr_wmask),
        .wb_ex        (wb_ex),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_ertn      (wb_ertn),
`ifdef WB_TRACE_EN
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt),
`endif
        .wb_flush     (wb_flush)
    );

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [WE_W-1:0]       rf_we;
        logic [4:0]            waddr;
        logic [XLEN-1:0]       wdata;
        logic                  csr_we;
        logic [13:0]           csr_num;
        logic [XLEN-1:0]       csr_wdata;
        logic [XLEN-1:0]       csr_wmask;
        logic                  ertn;
        logic [NUM_EXC-1:0]    exc_vec;
        logic [CW*NUM_EXC-1:0] exc_code;
    } instr_t;

    // Model state: the instruction held by the stage (if any) and whether the
    // next cycle is the flush cycle.
    instr_t      m_ins;
    bit          m_valid;
    bit          m_flushing;
    bit          m_acc;
    longint      m_cnt;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_exc();
        return m_valid && (m_ins.exc_vec != '0);
    endfunction

    function automatic bit m_ready();
        bit csr_pending;
        csr_pending = m_valid && !m_exc() && m_ins.csr_we;
        return !csr_pending || csr_wack;
    endfunction

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare();
        logic [14:0] code;
        bit          ex;
        bit          er;
        ex   = m_exc();
        er   = m_valid && m_ins.ertn && !ex;
        code = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (m_ins.exc_vec[i]) code = m_ins.exc_code[i*CW +: CW];
        end
        chk("wb_valid", wb_valid, m_valid);
        chk("wb_flush", wb_flush, m_flushing);
        chk("wb_allow_in", wb_allow_in, m_flushing ? 1'b1 : (!m_valid || m_ready()));
        chk("wb_ex", wb_ex, ex);
        chk("wb_ertn", wb_ertn, er);
        chk("wb_rf_we", wb_rf_we, (m_valid && !ex) ? m_ins.rf_we : '0);
        chk("wb_csr_we", wb_csr_we, m_valid && !ex && m_ins.csr_we);
        if (m_valid) begin
            chk("wb_pc", wb_pc, m_ins.pc);
            chk("wb_rf_waddr", wb_rf_waddr, m_ins.waddr);
            chk("wb_rf_wdata", wb_rf_wdata, m_ins.wdata);
            chk("wb_csr_num", wb_csr_num, m_ins.csr_num);
            chk("wb_csr_wdata", wb_csr_wdata, m_ins.csr_wdata);
            chk("wb_csr_wmask", wb_csr_wmask, m_ins.csr_wmask);
            chk("wb_ecode", wb_ecode, code[5:0]);
            chk("wb_esubcode", wb_esubcode, code[14:6]);
        end
`ifdef WB_TRACE_EN
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("debug_wb_rf_we", debug_wb_rf_we,
            (m_valid && m_ready() && !ex) ? m_ins.rf_we : '0);
        if (m_valid) begin
            chk("debug_wb_pc", debug_wb_pc, m_ins.pc);
            chk("debug_wb_rf_wnum", debug_wb_rf_wnum, m_ins.waddr);
            chk("debug_wb_rf_wdata", debug_wb_rf_wdata, m_ins.wdata);
        end
`endif
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit ex;
        bit er;
        bit rg;
        ex    = m_exc();
        er    = m_valid && m_ins.ertn && !ex;
        rg    = m_ready();
        m_acc = 1'b0;
        if (reset) begin
            m_valid    = 1'b0;
            m_flushing = 1'b0;
            m_ins      = '0;
            m_cnt      = 0;
        end else if (m_flushing) begin
            m_flushing = 1'b0;
        end else begin
            if (m_valid && rg && !ex) m_cnt++;
            if (m_valid && rg && (ex || er)) begin
                m_flushing = 1'b1;
                m_valid    = 1'b0;
            end else if (to_wb_valid && (!m_valid || rg)) begin
                m_valid = 1'b1;
                m_acc   = 1'b1;
                m_ins   = '{in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_csr_we,
                            in_csr_num, in_csr_wdata, in_csr_wmask, in_ertn,
                            in_exc_vec, in_exc_code};
            end else if (m_valid && rg) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: compare at the falling edge, step the model at the rising
    // edge, return shortly after so new inputs can be driven.
    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic clear_in();
        to_wb_valid  = 1'b0;
        in_pc        = '0;
        in_rf_we     = '0;
        in_rf_waddr  = '0;
        in_rf_wdata  = '0;
        in_csr_we    = 1'b0;
        in_csr_num   = '0;
        in_csr_wdata = '0;
        in_csr_wmask = '0;
        in_ertn      = 1'b0;
        in_exc_vec   = '0;
        in_exc_code  = '0;
        csr_wack     = 1'b0;
    endtask

    initial begin
        int sent;
        int budget;
        checks     = 0;
        errors     = 0;
        m_valid    = 1'b0;
        m_flushing = 1'b0;
        m_ins      = '0;
        m_cnt      = 0;
        clear_in();
        reset = 1'b1;
        @(posedge clk);
        model_step();
        #2;
        cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", wb_valid, 1'b0);
        chk("rst_pc", wb_pc, 32'h0);
        chk("rst_flush", wb_flush, 1'b0);
        chk("rst_allow_in", wb_allow_in, 1'b1);
        $display("txn reset: valid=%0b pc=%0h flush=%0b", wb_valid, wb_pc, wb_flush);

        // Plain register writeback
        to_wb_valid = 1'b1;
        in_pc = 32'h1C00_0000; in_rf_we = 4'hF; in_rf_waddr = 5'd5; in_rf_wdata = 32'h1234;
        cycle();
        clear_in();
        chk("rf_we_28", wb_rf_we, 4'hF);
        chk("waddr_28", wb_rf_waddr, 5'd5);
        chk("wdata_28", wb_rf_wdata, 32'h1234);
        chk("valid_28", wb_valid, 1'b1);
        $display("txn rf write: pc=%0h we=%0h waddr=%0d wdata=%0h", wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata);
        cycle();

        // Two exceptions raised; source 1 outranks source 2
        to_wb_valid = 1'b1;
        in_pc = 32'h1C00_0010; in_rf_we = 4'hF; in_rf_waddr = 5'd7;
        in_exc_vec = 4'b0110;
        in_exc_code = {15'h0, 15'h008, 15'h00B, 15'h0};
        cycle();
        clear_in();
        chk("ex_29", wb_ex, 1'b1);
        chk("ecode_29", wb_ecode, 6'h0B);
        chk("esub_29", wb_esubcode, 9'h0);
        chk("rf_we_29", wb_rf_we, 4'h0);
        $display("txn exception: ex=%0b ecode=%0h rf_we=%0h", wb_ex, wb_ecode, wb_rf_we);
        cycle();
        chk("flush_29", wb_flush, 1'b1);
        chk("valid_29", wb_valid, 1'b0);
        cycle();
        chk("flush_end_29", wb_flush, 1'b0);

        // CSR write stalls until ack; the next instruction waits upstream
        to_wb_valid = 1'b1;
        in_pc = 32'h1C00_0020; in_csr_we = 1'b1; in_csr_num = 14'h0006;
        in_csr_wdata = 32'hDEAD_BEEF; in_csr_wmask = 32'hFFFF_0000;
        cycle();
        in_pc = 32'h1C00_0024; in_csr_we = 1'b0; in_rf_we = 4'h3; in_rf_waddr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_allow_30", wb_allow_in, 1'b0);
            chk("stall_csr_we_30", wb_csr_we, 1'b1);
            $display("txn csr stall %0d: allow_in=%0b csr_we=%0b", i, wb_allow_in, wb_csr_we);
            cycle();
        end
        csr_wack = 1'b1;
        #1;
        chk("ack_allow_30", wb_allow_in, 1'b1);
        cycle();
        clear_in();
        chk("next_pc_30", wb_pc, 32'h1C00_0024);
        chk("next_csr_we_30", wb_csr_we, 1'b0);
        $display("txn csr ack: next pc=%0h", wb_pc);
        // Stray ack with no CSR write pending
        csr_wack = 1'b1;
        cycle();
        clear_in();

        // ertn: one FLUSH cycle, arriving instructions discarded meanwhile
        to_wb_valid = 1'b1; in_pc = 32'h1C00_0030; in_ertn = 1'b1;
        cycle();
        in_ertn = 1'b0; in_pc = 32'h0000_0040; in_rf_we = 4'h1;
        chk("ertn_31", wb_ertn, 1'b1);
        chk("ertn_ex_31", wb_ex, 1'b0);
        cycle();
        chk("ertn_flush_31", wb_flush, 1'b1);
        chk("ertn_valid_31", wb_valid, 1'b0);
        #1;
        chk("ertn_allow_31", wb_allow_in, 1'b1);
        cycle();
        chk("ertn_discard_31", wb_valid, 1'b0);
        chk("ertn_flush_end_31", wb_flush, 1'b0);
        $display("txn ertn: flush done, valid=%0b", wb_valid);
        cycle();
        clear_in();
        cycle();

        // Exception and ertn together: exception wins
        to_wb_valid = 1'b1; in_pc = 32'h1C00_0050; in_ertn = 1'b1;
        in_exc_vec = 4'b0001; in_exc_code = {45'h0, 15'h1C5};
        cycle();
        clear_in();
        chk("both_ex", wb_ex, 1'b1);
        chk("both_ertn", wb_ertn, 1'b0);
        chk("both_ecode", wb_ecode, 6'h05);
        chk("both_esub", wb_esubcode, 9'h007);
        $display("txn ex+ertn: ex=%0b ertn=%0b", wb_ex, wb_ertn);
        cycle();
        cycle();

        // Reset during FLUSH
        to_wb_valid = 1'b1; in_pc = 32'h1C00_0060; in_ertn = 1'b1;
        cycle();
        clear_in();
        cycle();
        chk("pre_rst_flush_32", wb_flush, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_flush_32", wb_flush, 1'b0);
        chk("rst_valid_32", wb_valid, 1'b0);
        $display("txn reset in flush: flush=%0b valid=%0b", wb_flush, wb_valid);

        // Reset during a CSR stall
        to_wb_valid = 1'b1; in_csr_we = 1'b1; in_rf_we = 4'hF;
        cycle();
        clear_in();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_stall_csr_we", wb_csr_we, 1'b0);
        chk("rst_stall_rf_we", wb_rf_we, 4'h0);
        $display("txn reset in stall: csr_we=%0b rf_we=%0h", wb_csr_we, wb_rf_we);

        // Ten back-to-back instructions, the fifth one excepting
        sent = 0;
        budget = 0;
        while (sent < 10 && budget < 60) begin
            to_wb_valid = 1'b1;
            in_pc = 32'h100 + 32'(sent * 4);
            in_rf_we = 4'hF; in_rf_waddr = 5'(sent + 1); in_rf_wdata = 32'(sent);
            in_exc_vec = (sent == 4) ? 4'b1000 : 4'b0000;
            in_exc_code = {15'h00A, 45'h0};
            cycle();
            if (m_acc) sent++;
            budget++;
        end
        chk("burst_sent", 64'(sent), 64'd10);
        chk("burst_cycles", 64'(budget), 64'd12);
        clear_in();
        cycle();
`ifdef WB_TRACE_EN
        chk("retire_cnt_33", retire_cnt, 64'd9);
        $display("txn burst: retire_cnt=%0d", retire_cnt);
`endif
        $display("txn burst: sent=%0d cycles=%0d", sent, budget);

        // Mixed random traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            to_wb_valid  = 1'($urandom_range(0, 1));
            in_pc        = $urandom;
            in_rf_we     = 4'($urandom);
            in_rf_waddr  = 5'($urandom);
            in_rf_wdata  = $urandom;
            in_csr_we    = ($urandom_range(0, 2) == 0);
            in_csr_num   = 14'($urandom);
            in_csr_wdata = $urandom;
            in_csr_wmask = $urandom;
            in_ertn      = ($urandom_range(0, 5) == 0);
            in_exc_vec   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            in_exc_code  = {28'($urandom), $urandom};
            csr_wack     = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 39) == 0);
            cycle();
            $display("txn rand %0d: valid=%0b pc=%0h ex=%0b flush=%0b", i, wb_valid, wb_pc, wb_ex, wb_flush);
        end
        reset = 1'b0;
        clear_in();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage_param.md
WB_STAGE_PARAM -- requirements
Module: wb_stage_param

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; WE_W, default 4, register-file byte-write-enable width; NUM_EXC, default 4, exception sources (index 0 highest priority).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: to_wb_valid  in  1  upstream instruction valid; wb_allow_in  out  1  stage accepts; wb_valid  out  1  stage holds instruction.
REQ-004 SHALL have ports: in_pc  in  XLEN  PC; in_rf_we  in  WE_W; in_rf_waddr  in  5; in_rf_wdata  in  XLEN  register writeback payload.
REQ-005 SHALL have ports: in_csr_we  in  1; in_csr_num  in  14; in_csr_wdata  in  XLEN; in_csr_wmask  in  XLEN  CSR write payload.
REQ-006 SHALL have ports: in_ertn  in  1  return-from-exception; in_exc_vec  in  NUM_EXC  raised exceptions; in_exc_code  in  15*NUM_EXC  per-source {esubcode[8:0],ecode[5:0]}.
REQ-007 SHALL have port: csr_wack  in  1  CSR file acknowledges the current write.
REQ-008 SHALL have ports: wb_pc  out  XLEN; wb_rf_we  out  WE_W; wb_rf_waddr  out  5; wb_rf_wdata  out  XLEN.
REQ-009 SHALL have ports: wb_csr_we  out  1; wb_csr_num  out  14; wb_csr_wdata  out  XLEN; wb_csr_wmask  out  XLEN.
REQ-010 SHALL have ports: wb_ex  out  1; wb_ecode  out  6; wb_esubcode  out  9; wb_ertn  out  1; wb_flush  out  1  squash upstream.

Function
REQ-011 SHALL register all in_* payload on accept (to_wb_valid && wb_allow_in); payload held otherwise.
REQ-012 SHALL compute wb_allow_in = !wb_valid || (wb_ready_go && state==RUN).
REQ-013 SHALL compute wb_ready_go = !(wb_csr_we) || csr_wack; stall until CSR ack.
REQ-014 SHALL select wb_ecode/wb_esubcode from lowest-index set bit of latched exc_vec; zero when none.
REQ-015 SHALL assert wb_ex = wb_valid && |exc_vec; wb_ertn = wb_valid && ertn && !wb_ex.
REQ-016 SHALL gate wb_rf_we to 0 and wb_csr_we to 0 when !wb_valid or wb_ex.
REQ-017 SHALL implement FSM RUN, FLUSH; RUN->FLUSH when wb_valid && wb_ready_go && (wb_ex || wb_ertn); FLUSH->RUN unconditionally next cycle.
REQ-018 SHALL assert wb_flush only in FLUSH; wb_valid SHALL be 0 in FLUSH and to_wb_valid SHALL be discarded then (wb_allow_in=1).
REQ-019 SHALL retire (clear wb_valid) when wb_ready_go and no new accept; back-to-back accept with zero bubbles in RUN.
REQ-020 SHALL treat exception and ertn together: exception wins, ertn suppressed.
REQ-021 SHALL, on csr_wack without wb_csr_we, ignore it.

Reset
REQ-022 SHALL on reset clear wb_valid, state=RUN; all outputs 0 (wb_pc, payload regs 0, wb_flush 0).
REQ-023 SHALL on reset mid-stall or mid-FLUSH drop the instruction with no write or flush output next cycle.

Configuration
REQ-024 SHALL, with WB_TRACE_EN defined, add outputs debug_wb_pc XLEN, debug_wb_rf_we WE_W, debug_wb_rf_wnum 5, debug_wb_rf_wdata XLEN (mirroring gated writeback on retire) and retire_cnt 64 counting retired non-exception instructions, reset 0, wrapping.
REQ-025 SHALL, without WB_TRACE_EN, omit those ports and the counter entirely.

Structure
REQ-026 SHALL place FSM state typedef, ecode/esubcode widths and EXC_CODE_W=15 in shared package wb_pkg.
REQ-027 SHALL implement priority selection in sub-module wb_exc_prio (NUM_EXC-parameterised).

Verification
REQ-028 Accept pc=0x1C000000, rf_we=0xF, waddr=5, wdata=0x1234 -> next cycle wb_rf_we=0xF, waddr=5, wdata=0x1234, wb_valid=1.
REQ-029 exc_vec=4'b0110, code[1]=0x00B, code[2]=0x008 -> wb_ex=1, wb_ecode=0x0B, wb_rf_we=0, next cycle wb_flush=1, wb_valid=0.
REQ-030 csr_we=1, csr_wack low 3 cycles -> wb_allow_in=0 3 cycles, retire on 4th; wb_csr_we held.
REQ-031 ertn with exc_vec=0 -> wb_ertn=1, one FLUSH cycle; to_wb_valid=1 in FLUSH discarded.
REQ-032 reset asserted during FLUSH -> next cycle state RUN, wb_flush=0, wb_valid=0.
REQ-033 WB_TRACE_EN, 10 back-to-back instructions, one excepting -> retire_cnt=9.
